// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch condition resolver with a bimodal
// branch history table of 2-bit saturating counters read by IF.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned BHT_DEPTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pred_pc,
    output logic                pred_taken,
    input  logic                res_valid,
    input  logic [PC_WIDTH-1:0] res_pc,
    input  logic [WIDTH-1:0]    cmpA,
    input  logic [WIDTH-1:0]    cmpB,
    input  logic [2:0]          branchOp,
    input  logic                res_pred_taken,
    input  logic                stall,
    output logic                jumpEn,
    output logic                mispredict,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctrState_t;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_NE  = 3'd1,
        OP_LT  = 3'd2,
        OP_LE  = 3'd3,
        OP_LTU = 3'd4,
        OP_GT  = 3'd5,
        OP_GTU = 3'd6,
        OP_GE  = 3'd7
    } branchOp_t;

    ctrState_t        bht [BHT_DEPTH];
    logic [IDX_W-1:0] predIdx;
    logic [IDX_W-1:0] resIdx;
    ctrState_t        predCtr;
    ctrState_t        resCtr;
    ctrState_t        resCtrNext;
    logic             isEq;
    logic             signedLt;
    logic             unsignedLt;
    logic             condMet;
    logic             doUpdate;
    logic             unusedPcBits;

    // Word-aligned index; offset bits and upper PC bits are deliberately dropped.
    assign predIdx      = pred_pc[IDX_W+1:2];
    assign resIdx       = res_pc[IDX_W+1:2];
    assign unusedPcBits = ^{pred_pc, res_pc};

    // Read-before-write: IF always sees the registered value, no bypass.
    assign predCtr    = bht[predIdx];
    assign pred_taken = predCtr[1];
    assign resCtr     = bht[resIdx];

    assign isEq       = (cmpA == cmpB);
    assign signedLt   = ($signed(cmpA) < $signed(cmpB));
    assign unsignedLt = (cmpA < cmpB);

    // Condition select from the shared equality / less-than terms.
    always_comb begin
        condMet = 1'b0;
        case (branchOp)
            OP_EQ:   condMet = isEq;
            OP_NE:   condMet = !isEq;
            OP_LT:   condMet = signedLt;
            OP_LE:   condMet = signedLt | isEq;
            OP_LTU:  condMet = unsignedLt;
            OP_GT:   condMet = !(signedLt | isEq);
            OP_GTU:  condMet = !(unsignedLt | isEq);
            OP_GE:   condMet = !signedLt;
            default: condMet = 1'b0;
        endcase
    end

    assign jumpEn     = res_valid & condMet;
    assign mispredict = res_valid & (jumpEn != res_pred_taken);
    assign doUpdate   = res_valid & ~stall;

    // Saturating step of the resolving branch's counter toward the outcome.
    always_comb begin
        resCtrNext = resCtr;
        if (jumpEn) begin
            if (resCtr != STRONG_T) begin
                resCtrNext = ctrState_t'(resCtr + 2'd1);
            end
        end else begin
            if (resCtr != STRONG_NT) begin
                resCtrNext = ctrState_t'(resCtr - 2'd1);
            end
        end
    end

    // Table write: reset to weak-NT everywhere, otherwise one entry per update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= WEAK_NT;
            end
        end else if (doUpdate) begin
            bht[resIdx] <= resCtrNext;
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] brCnt;
    logic [31:0] misCnt;

    // Resolved-branch and misprediction counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            brCnt  <= '0;
            misCnt <= '0;
        end else if (doUpdate) begin
            if (brCnt != '1) begin
                brCnt <= brCnt + 32'd1;
            end
            if (mispredict && (misCnt != '1)) begin
                misCnt <= misCnt + 32'd1;
            end
        end
    end

    assign br_count      = brCnt;
    assign mispred_count = misCnt;
`else
    assign br_count      = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit.
// Expected statistics follow BRU_STATS_EN (zero when the macro is undefined).
module tb_branch_resolve_unit;

`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] cmpA;
    logic [31:0] cmpB;
    logic [2:0]  branchOp;
    logic        res_pred_taken;
    logic        stall;
    logic        jumpEn;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(
        .WIDTH    (32),
        .PC_WIDTH (32),
        .BHT_DEPTH(64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .cmpA          (cmpA),
        .cmpB          (cmpB),
        .branchOp      (branchOp),
        .res_pred_taken(res_pred_taken),
        .stall         (stall),
        .jumpEn        (jumpEn),
        .mispredict    (mispredict),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expCnt(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    // Present one resolving branch (EQ op; taken when operands match).
    task automatic drive(input logic [31:0] pc, input logic tk, input logic predTk, input logic stl);
        @(negedge clk);
        res_valid      = 1'b1;
        res_pc         = pc;
        cmpA           = 32'd1;
        cmpB           = tk ? 32'd1 : 32'd2;
        branchOp       = 3'd0;
        res_pred_taken = predTk;
        stall          = stl;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        res_valid      = 1'b0;
        stall          = 1'b0;
        res_pred_taken = 1'b0;
        #1;
    endtask

    logic [31:0] vecA [4];
    logic [31:0] vecB [4];
    logic [7:0]  vecMask [4];

    initial begin
        vecA[0] = 32'hFFFF_FFFF; vecB[0] = 32'd1;          vecMask[0] = 8'h4E;
        vecA[1] = 32'd5;         vecB[1] = 32'd5;          vecMask[1] = 8'h89;
        vecA[2] = 32'd2;         vecB[2] = 32'd7;          vecMask[2] = 8'h1E;
        vecA[3] = 32'h8000_0000; vecB[3] = 32'h7FFF_FFFF;  vecMask[3] = 8'h4E;

        reset = 1'b1; pred_pc = '0; res_valid = 1'b0; res_pc = '0;
        cmpA = '0; cmpB = '0; branchOp = '0; res_pred_taken = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        pred_pc = 32'h0000_3000;
        #1;
        checkVal("rst_pred", pred_taken, 0);
        checkVal("rst_br", br_count, 0);
        checkVal("rst_mis", mispred_count, 0);
        checkVal("rst_jump", jumpEn, 0);

        // Comparator sweep under stall so the table stays untouched.
        for (int v = 0; v < 4; v++) begin
            for (int op = 0; op < 8; op++) begin
                @(negedge clk);
                res_valid = 1'b1; stall = 1'b1; res_pred_taken = 1'b0;
                cmpA = vecA[v]; cmpB = vecB[v]; branchOp = 3'(op);
                #1;
                checkVal($sformatf("cmp%0d_op%0d", v, op), jumpEn, vecMask[v][op]);
                checkVal($sformatf("mis%0d_op%0d", v, op), mispredict, vecMask[v][op]);
            end
        end
        @(negedge clk);
        res_valid = 1'b0; res_pred_taken = 1'b1; cmpA = 32'd3; cmpB = 32'd4; branchOp = 3'd1;
        #1;
        checkVal("novalid_jump", jumpEn, 0);
        checkVal("novalid_mis", mispredict, 0);
        checkVal("sweep_br", br_count, 0);

        // Training to saturation at 0x3010.
        pred_pc = 32'h0000_3010;
        drive(32'h0000_3010, 1'b1, 1'b0, 1'b0);
        checkVal("tr1_pred", pred_taken, 0);
        checkVal("tr1_mis", mispredict, 1);
        drive(32'h0000_3010, 1'b1, 1'b0, 1'b0);
        checkVal("tr2_pred", pred_taken, 1);
        checkVal("tr2_mis", mispredict, 1);
        drive(32'h0000_3010, 1'b1, 1'b0, 1'b0);
        checkVal("tr3_pred", pred_taken, 1);
        checkVal("tr3_mis", mispredict, 1);
        idle();
        checkVal("tr_sat_pred", pred_taken, 1);
        checkVal("tr_br", br_count, expCnt(3));
        checkVal("tr_mis", mispred_count, expCnt(3));
        drive(32'h0000_3010, 1'b0, 1'b1, 1'b0);
        checkVal("nt1_mis", mispredict, 1);
        drive(32'h0000_3010, 1'b0, 1'b0, 1'b0);
        checkVal("nt1_pred", pred_taken, 1);
        checkVal("nt2_mis", mispredict, 0);
        idle();
        checkVal("nt2_pred", pred_taken, 0);
        checkVal("nt_br", br_count, expCnt(5));
        checkVal("nt_mis", mispred_count, expCnt(4));

        // Stall hold at 0x3020.
        pred_pc = 32'h0000_3020;
        for (int c = 0; c < 5; c++) begin
            drive(32'h0000_3020, 1'b1, 1'b0, 1'b1);
            checkVal($sformatf("stall%0d_jump", c), jumpEn, 1);
        end
        idle();
        checkVal("stall_pred", pred_taken, 0);
        checkVal("stall_br", br_count, expCnt(5));
        drive(32'h0000_3020, 1'b1, 1'b0, 1'b0);
        idle();
        checkVal("stall_entry01", pred_taken, 1);

        // Read/write collision at 0x3040.
        pred_pc = 32'h0000_3040;
        drive(32'h0000_3040, 1'b1, 1'b0, 1'b0);
        checkVal("coll_same", pred_taken, 0);
        idle();
        checkVal("coll_next", pred_taken, 1);
        checkVal("coll_br", br_count, expCnt(7));

        // Aliasing: 0x3000 and 0x3100 share index 0; 0x3004 does not.
        pred_pc = 32'h0000_3100;
        drive(32'h0000_3000, 1'b1, 1'b0, 1'b0);
        idle();
        checkVal("alias_3100", pred_taken, 1);
        pred_pc = 32'h0000_3003;
        #1;
        checkVal("alias_offset", pred_taken, 1);
        pred_pc = 32'h0000_3004;
        #1;
        checkVal("alias_neighbor", pred_taken, 0);

        // Reset concurrent with a taken update wins.
        pred_pc = 32'h0000_3000;
        drive(32'h0000_3000, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; res_valid = 1'b0;
        #1;
        checkVal("rstmid_pred", pred_taken, 0);
        checkVal("rstmid_br", br_count, 0);
        checkVal("rstmid_mis", mispred_count, 0);
        pred_pc = 32'h0000_3040;
        #1;
        checkVal("rstmid_3040", pred_taken, 0);
        pred_pc = 32'h0000_3000;
        drive(32'h0000_3000, 1'b1, 1'b0, 1'b0);
        idle();
        checkVal("rstmid_entry01", pred_taken, 1);
        checkVal("post_br", br_count, expCnt(1));
        checkVal("post_mis", mispred_count, expCnt(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the ID-stage branch comparator for the pipelined CPU.
- Resolves the branch condition with correct signed and unsigned semantics.
- Holds a BHT_DEPTH-entry table of 2-bit saturating counters, which IF reads for direction prediction.
- Updates the table when a branch resolves in ID, and flags mispredictions to the hazard/flush logic.

Parameters:
- WIDTH, 32, operand width of cmpA/cmpB.
- PC_WIDTH, 32, PC width.
- BHT_DEPTH, 64, number of predictor entries; power of two, at least 2; IDX_W = log2(BHT_DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pred_pc  in  PC_WIDTH  IF-stage PC for lookup.
- pred_taken  out  1  IF prediction; combinational read of the table.
- res_valid  in  1  ID holds a conditional branch this cycle.
- res_pc  in  PC_WIDTH  PC of the resolving branch.
- cmpA  in  WIDTH  forwarded rs value.
- cmpB  in  WIDTH  forwarded rt value (or zero for the *z forms).
- branchOp  in  3  condition select.
- res_pred_taken  in  1  prediction carried down from IF with the branch.
- stall  in  1  ID frozen; suppresses all state updates.
- jumpEn  out  1  condition result (combinational).
- mispredict  out  1  res_valid & (jumpEn != res_pred_taken) (combinational).
- br_count  out  32  resolved-branch counter (optional feature).
- mispred_count  out  32  misprediction counter (optional feature).

Behaviour:
- branchOp encoding:
  - 0 EQ, 1 NE, 2 LT signed, 3 LE signed.
  - 4 LTU unsigned, 5 GT signed, 6 GTU unsigned, 7 GE signed.
- Signed ops compare as two's complement WIDTH-bit values; unsigned ops compare raw values.
- jumpEn = 0 when res_valid = 0.
- Index = pc[IDX_W+1:2]; the word-offset bits [1:0] are ignored. Upper PC bits alias.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. pred_taken = counter[1] of entry(pred_pc).
- Update, at the clock edge when res_valid & !stall & !reset:
  - jumpEn = 1: counter increments, saturating at 11.
  - jumpEn = 0: counter decrements, saturating at 00.
  - Exactly one entry changes per cycle.
- Read/write collision (pred_pc and res_pc map to the same index in the same cycle): pred_taken shows the pre-update value, i.e. read-before-write. No bypass.
- stall = 1: table and counters hold. jumpEn and mispredict remain combinationally valid so the hazard unit can observe them.
- Reset: all entries go to 01 (weak-NT), so pred_taken = 0 the cycle after reset. br_count = 0, mispred_count = 0.
- Reset asserted mid-operation wins over any simultaneous update.
- Latency:
  - jumpEn, mispredict, pred_taken: 0 cycles (combinational).
  - Table update: visible on pred_taken the cycle after the resolving edge.
- mispredict is not registered; the flush logic samples it in the same cycle.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - br_count increments on each update edge (res_valid & !stall).
  - mispred_count increments on each update edge where mispredict = 1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Undefined:
  - Both outputs are tied to 0 and no counter registers are synthesised.
  - Ports remain present in both builds.

Test Plan:
- Comparator semantics: cmpA=32'hFFFF_FFFF, cmpB=1, res_valid=1. Sweep branchOp 0..7 -> jumpEn = 0,1,1,1,0,0,1,0.
- Reset state: after reset, pred_pc=32'h0000_3000 -> pred_taken=0. Counter stats read 0.
- Training and saturation: res_pc=32'h0000_3010 taken 3 consecutive non-stalled cycles, res_pred_taken=0 each time.
  - pred_taken at 0x3010 becomes 1 after the first update (01->10).
  - mispredict=1 on all 3 cycles; mispred_count=3.
  - 2 not-taken updates -> pred_taken returns to 0 after the second (11->10->01).
- Stall hold: res_valid=1, stall=1, taken branch at 0x3020 for 5 cycles -> entry stays 01, br_count unchanged, jumpEn=1 throughout.
- Collision: pred_pc=res_pc=0x3040, entry at 01, taken update. pred_taken=0 that cycle and 1 the next.
- Aliasing and reset mid-run: with BHT_DEPTH=64, training 0x3000 affects 0x3100. Reset asserted alongside a taken update -> entry is 01 afterwards.
